// File: rtl/noc_vc_pkg.sv
// Shared definitions for the two-VC NoC link: VC count, VC id type, TX FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_vc_pkg;

   localparam int NUM_VC = 2;

   typedef logic vc_id_t;

   typedef enum logic {
      TX_IDLE,
      TX_LOCK
   } tx_state_e;

   // Bits needed to hold a credit count in the range 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC credit counter mirroring free slots in the downstream FIFO.
// Latency: count updates one cycle after dec/inc; nonzero/overflow reflect the current count.
// Backpressure: nonzero gates eligibility; returns at full count saturate and flag overflow.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count resets to DEPTH)
//   dec         a flit was accepted on this VC this cycle
//   inc         downstream returned one credit this cycle
//   nonzero     at least one credit is available
//   overflow    a return arrived with the count already at DEPTH and no accept
module vc_credit_counter
   import noc_vc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dec,
   input  logic inc,
   output logic nonzero,
   output logic overflow
);

   localparam int            CW  = credit_width(DEPTH);
   localparam logic [CW-1:0] MAX = CW'(DEPTH);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d    = cnt_q;
      overflow = 1'b0;
      // A simultaneous accept and return cancel out, so only the one-sided
      // cases move the count.
      if (dec && !inc) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (inc && !dec) begin
         if (cnt_q == MAX) begin
            overflow = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign nonzero = (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= MAX;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vc_tx_2vc.sv
// Two-VC transmit arbiter: round-robin between VCs, packet-atomic, credit-gated onto one link.
// Latency: a flit accepted in cycle N appears on out_data with a one-cycle out_wrreq pulse in N+1.
// Backpressure: in_ready is combinational; a VC stalls at zero credits, and a locked VC stalls the whole link.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      per-VC flits, VC v at [v*WIDTH +: WIDTH]
//   in_valid     per-VC flit valid
//   in_last      per-VC tail-flit marker
//   in_ready     per-VC accept (one-hot or zero)
//   out_data     registered link flit, held when idle
//   out_wrreq    registered one-hot per-VC downstream write strobe
//   credit_ret   per-VC credit return from downstream
//   credit_err   sticky: credit returned with the counter already full
//   flit_cnt, pkt_cnt  (only with VC_TX_STATS_EN) per-VC 32-bit counters, VC v at [v*32 +: 32]
module vc_tx_2vc
   import noc_vc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_VC*WIDTH-1:0] in_data,
   input  logic [NUM_VC-1:0]       in_valid,
   input  logic [NUM_VC-1:0]       in_last,
   output logic [NUM_VC-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [NUM_VC-1:0]       out_wrreq,
   input  logic [NUM_VC-1:0]       credit_ret,
   output logic                    credit_err
`ifdef VC_TX_STATS_EN
   ,
   output logic [NUM_VC*32-1:0]    flit_cnt,
   output logic [NUM_VC*32-1:0]    pkt_cnt
`endif
);

   logic [NUM_VC-1:0] nonzero;
   logic [NUM_VC-1:0] ovf;
   logic [NUM_VC-1:0] eligible;

   tx_state_e state_q, state_d;
   vc_id_t    lock_q, lock_d;
   vc_id_t    rr_q, rr_d;
   logic      grant_vld;
   vc_id_t    grant_vc;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_cc
      vc_credit_counter #(
         .DEPTH(DEPTH)
      ) u_cc (
         .clk     (clk),
         .rst_n   (rst_n),
         .dec     (in_ready[v]),
         .inc     (credit_ret[v]),
         .nonzero (nonzero[v]),
         .overflow(ovf[v])
      );
   end

   assign eligible = in_valid & nonzero;

   always_comb begin
      state_d   = state_q;
      lock_d    = lock_q;
      rr_d      = rr_q;
      grant_vld = 1'b0;
      grant_vc  = rr_q;
      in_ready  = '0;
      case (state_q)
         TX_IDLE: begin
            if (eligible[rr_q]) begin
               grant_vld = 1'b1;
               grant_vc  = rr_q;
            end else if (eligible[~rr_q]) begin
               grant_vld = 1'b1;
               grant_vc  = ~rr_q;
            end
            if (grant_vld) begin
               if (in_last[grant_vc]) begin
                  rr_d = ~grant_vc;
               end else begin
                  state_d = TX_LOCK;
                  lock_d  = grant_vc;
               end
            end
         end
         TX_LOCK: begin
            // The owning VC keeps the link even while out of credits; the
            // other VC is never slipped in, so packets stay contiguous.
            grant_vc = lock_q;
            if (eligible[lock_q]) begin
               grant_vld = 1'b1;
               if (in_last[lock_q]) begin
                  state_d = TX_IDLE;
                  rr_d    = ~lock_q;
               end
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
      if (grant_vld) begin
         in_ready[grant_vc] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         lock_q  <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_wrreq  <= '0;
         credit_err <= 1'b0;
      end else begin
         out_wrreq  <= in_ready;
         credit_err <= credit_err | (|ovf);
         if (grant_vld) begin
            out_data <= in_data[int'(grant_vc)*WIDTH +: WIDTH];
         end
      end
   end

`ifdef VC_TX_STATS_EN
   logic [31:0] flit_q [NUM_VC];
   logic [31:0] pkt_q  [NUM_VC];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            flit_q[v] <= '0;
            pkt_q[v]  <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (in_ready[v]) begin
               flit_q[v] <= flit_q[v] + 32'd1;
               if (in_last[v]) begin
                  pkt_q[v] <= pkt_q[v] + 32'd1;
               end
            end
         end
      end
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_stats
      assign flit_cnt[v*32 +: 32] = flit_q[v];
      assign pkt_cnt[v*32 +: 32]  = pkt_q[v];
   end
`endif

endmodule

// File: tb/tb_vc_tx_2vc.sv
// Directed self-checking bench for vc_tx_2vc (DEPTH=4, WIDTH=512).
// Latency: checks in_ready before each edge and out_wrreq/out_data one cycle later.
// Backpressure: exercises credit exhaustion, locked-VC stalls and credit overflow.
module tb_vc_tx_2vc;

   localparam int DEPTH = 4;
   localparam int WIDTH = 512;

   logic               clk;
   logic               rst_n;
   logic [2*WIDTH-1:0] in_data;
   logic [1:0]         in_valid;
   logic [1:0]         in_last;
   logic [1:0]         in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_wrreq;
   logic [1:0]         credit_ret;
   logic               credit_err;
`ifdef VC_TX_STATS_EN
   logic [63:0]        flit_cnt;
   logic [63:0]        pkt_cnt;
`endif

   int n_assert;
   int n_fail;
   logic [WIDTH-1:0] exp_data;

   vc_tx_2vc #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_wrreq (out_wrreq),
      .credit_ret(credit_ret),
      .credit_err(credit_err)
`ifdef VC_TX_STATS_EN
      ,
      .flit_cnt  (flit_cnt),
      .pkt_cnt   (pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] pat(input int vc, input int k);
      logic [63:0] w;
      w = 64'hC0DE_0000_0000_0000 | (64'(vc) << 8) | 64'(k);
      return {8{w}};
   endfunction

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_flits(input logic [1:0] vld, input logic [1:0] last, input int k);
      in_valid = vld;
      in_last  = last;
      in_data  = {pat(1, k), pat(0, k)};
   endtask

   // Called just after a rising edge with inputs already driven: checks the
   // combinational grant, crosses the next edge, then checks the link outputs.
   task automatic cyc(input string tag, input logic [1:0] exp_rdy);
      #1;
      chk({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(exp_rdy));
      if (exp_rdy == 2'b01) exp_data = in_data[WIDTH-1:0];
      else if (exp_rdy == 2'b10) exp_data = in_data[2*WIDTH-1:WIDTH];
      @(posedge clk);
      #1;
      chk({tag, ".out_wrreq"}, WIDTH'(out_wrreq), WIDTH'(exp_rdy));
      chk({tag, ".out_data"}, out_data, exp_data);
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      exp_data   = '0;
      rst_n      = 1'b0;
      in_data    = '0;
      in_valid   = 2'b00;
      in_last    = 2'b00;
      credit_ret = 2'b00;

      // Reset state
      #3;
      chk("rst.out_wrreq", WIDTH'(out_wrreq), '0);
      chk("rst.out_data", out_data, '0);
      chk("rst.credit_err", WIDTH'(credit_err), '0);
      chk("rst.in_ready", WIDTH'(in_ready), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single-flit packets on both VCs: strict alternation, no bubbles
      for (int k = 0; k < 4; k++) begin
         set_flits(2'b11, 2'b11, k);
         cyc("alt", (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      set_flits(2'b00, 2'b11, 4);
      cyc("alt_idle", 2'b00);
      credit_ret = 2'b11;
      cyc("alt_ret0", 2'b00);
      cyc("alt_ret1", 2'b00);
      credit_ret = 2'b00;
      chk("alt.credit_err", WIDTH'(credit_err), '0);

      // 3-flit VC1 packet vs single-flit VC0 packets: VC0 first, then VC1 contiguous
      set_flits(2'b11, 2'b01, 10);
      cyc("pkt_vc0", 2'b01);
      set_flits(2'b11, 2'b01, 11);
      cyc("pkt_vc1_f0", 2'b10);
      set_flits(2'b11, 2'b01, 12);
      cyc("pkt_vc1_f1", 2'b10);
      set_flits(2'b11, 2'b11, 13);
      cyc("pkt_vc1_f2", 2'b10);
      set_flits(2'b01, 2'b11, 14);
      cyc("pkt_vc0_next", 2'b01);
      set_flits(2'b00, 2'b00, 15);
      cyc("pkt_idle", 2'b00);
      credit_ret = 2'b11;
      cyc("pkt_ret0", 2'b00);
      cyc("pkt_ret1", 2'b00);
      credit_ret = 2'b10;
      cyc("pkt_ret2", 2'b00);
      credit_ret = 2'b00;

      // Credit exhaustion on VC0: four accepted, then stall until a return
      for (int k = 20; k < 24; k++) begin
         set_flits(2'b01, 2'b01, k);
         cyc("exh_acc", 2'b01);
      end
      set_flits(2'b01, 2'b01, 24);
      cyc("exh_stall", 2'b00);
      credit_ret = 2'b01;
      cyc("exh_nobypass", 2'b00);
      credit_ret = 2'b00;
      cyc("exh_5th", 2'b01);
      cyc("exh_empty", 2'b00);
      set_flits(2'b00, 2'b00, 25);

      // VC0 locked with zero credits: VC1 must not be granted
      credit_ret = 2'b01;
      cyc("lock_ret", 2'b00);
      credit_ret = 2'b00;
      set_flits(2'b01, 2'b00, 30);
      cyc("lock_head", 2'b01);
      set_flits(2'b11, 2'b11, 31);
      cyc("lock_stall0", 2'b00);
      cyc("lock_stall1", 2'b00);
      credit_ret = 2'b01;
      cyc("lock_stall2", 2'b00);
      credit_ret = 2'b00;
      cyc("lock_tail", 2'b01);
      set_flits(2'b10, 2'b11, 32);
      cyc("lock_vc1", 2'b10);
      set_flits(2'b00, 2'b00, 33);
      credit_ret = 2'b11;
      cyc("lock_ret1", 2'b00);
      credit_ret = 2'b01;
      for (int i = 0; i < 3; i++) cyc("lock_ret2", 2'b00);
      credit_ret = 2'b00;
      chk("lock.credit_err", WIDTH'(credit_err), '0);

      // Same-cycle accept and return on VC0 at 2 credits leaves 2 credits
      set_flits(2'b01, 2'b01, 40);
      cyc("same_a0", 2'b01);
      set_flits(2'b01, 2'b01, 41);
      cyc("same_a1", 2'b01);
      set_flits(2'b01, 2'b01, 42);
      credit_ret = 2'b01;
      cyc("same_both", 2'b01);
      credit_ret = 2'b00;
      set_flits(2'b01, 2'b01, 43);
      cyc("same_a3", 2'b01);
      set_flits(2'b01, 2'b01, 44);
      cyc("same_a4", 2'b01);
      set_flits(2'b01, 2'b01, 45);
      cyc("same_stall", 2'b00);
      set_flits(2'b00, 2'b00, 46);
      chk("same.credit_err", WIDTH'(credit_err), '0);

      // Overflow on VC1 at full credits: sticky error, count saturates at DEPTH
      credit_ret = 2'b10;
      cyc("ovf_ret", 2'b00);
      credit_ret = 2'b00;
      chk("ovf.credit_err_set", WIDTH'(credit_err), WIDTH'(1));
      cyc("ovf_hold0", 2'b00);
      cyc("ovf_hold1", 2'b00);
      chk("ovf.credit_err_held", WIDTH'(credit_err), WIDTH'(1));
      for (int k = 50; k < 54; k++) begin
         set_flits(2'b10, 2'b11, k);
         cyc("ovf_sat_acc", 2'b10);
      end
      set_flits(2'b10, 2'b11, 54);
      cyc("ovf_sat_stall", 2'b00);
      set_flits(2'b00, 2'b00, 55);
      credit_ret = 2'b01;
      for (int i = 0; i < 4; i++) cyc("ovf_vc0_ret", 2'b00);
      credit_ret = 2'b00;

      // Reset mid-packet on VC0
      set_flits(2'b01, 2'b00, 60);
      cyc("mid_f0", 2'b01);
      set_flits(2'b01, 2'b00, 61);
      cyc("mid_f1", 2'b01);
      rst_n    = 1'b0;
      in_valid = 2'b00;
      #1;
      exp_data = '0;
      chk("mid_rst.out_wrreq", WIDTH'(out_wrreq), '0);
      chk("mid_rst.out_data", out_data, '0);
      chk("mid_rst.credit_err", WIDTH'(credit_err), '0);
      chk("mid_rst.in_ready", WIDTH'(in_ready), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // VC1 had no credits and VC0 was locked before reset: a grant here
      // shows both credits and FSM were cleared.
      set_flits(2'b10, 2'b11, 62);
      cyc("post_vc1", 2'b10);
      set_flits(2'b11, 2'b11, 63);
      cyc("post_vc0", 2'b01);
      set_flits(2'b00, 2'b00, 64);
      cyc("post_idle", 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
